cga_mic_incseq: RTL and testbench

Sequencer for the two-bit microcode word counter (INCOUNT) in the CGA MIC section. It presets the counter with a start index, then advances it by one each cycle a word is accepted. When the counter reaches a programmed terminal index it reports completion. It drives the counter's load and enable inputs, reads back the counter's active-low state, and hands the handshake to the surrounding micro-sequencer.

---
 rtl/cga_mic_incseq.sv | 148 ++++++++++++++
 tb/tb_cga_mic_incseq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cga_mic_incseq.sv
// cga_mic_incseq: sequencer for the two-bit INCOUNT microcode word counter.
// Presets the counter with a start index, advances it once per accepted
// word and pulses DONE when the read-back count has reached the terminal
// index. Optional watchdog abort is compiled in with CGA_MIC_INCSEQ_WDOG_EN.
module cga_mic_incseq #(
  parameter int unsigned WDOG_LIM = 15
) (
  input  logic       MCLK,
  input  logic       MRN,
  input  logic       START,
  input  logic [1:0] FIRST,
  input  logic [1:0] LAST,
  input  logic       WRDY,
  input  logic       CSWAN0,
  input  logic       CSWAN1,
  output logic       LWCAN,
  output logic       EC,
  output logic       CD0,
  output logic       CD1,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] first_reg, first_next;
  logic [1:0] last_reg, last_next;
  logic [1:0] count;

  // The terminal compare uses the counter's own state, so a stuck counter
  // shows up as a RUN that never ends instead of being masked.
  assign count = ~{CSWAN1, CSWAN0};

  // The limit must fit the 4-bit idle counter; an out-of-range value is
  // left without a dedicated block so it stands out at elaboration review.
  if (WDOG_LIM < 1 || WDOG_LIM > 15) begin : g_wdog_lim_out_of_range
  end

`ifdef CGA_MIC_INCSEQ_WDOG_EN
  localparam logic [3:0] WDOG_LIM4 = 4'(WDOG_LIM);
  logic [3:0] wdog_reg, wdog_next;
  logic       err_reg, err_next;
`endif

  // State and latched transfer parameters.
  always_ff @(posedge MCLK or negedge MRN) begin
    if (!MRN) begin
      state_reg <= ST_IDLE;
      first_reg <= 2'b00;
      last_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      first_reg <= first_next;
      last_reg  <= last_next;
    end
  end

`ifdef CGA_MIC_INCSEQ_WDOG_EN
  // Watchdog idle counter and the error flag shown alongside DONE.
  always_ff @(posedge MCLK or negedge MRN) begin
    if (!MRN) begin
      wdog_reg <= 4'd0;
      err_reg  <= 1'b0;
    end else begin
      wdog_reg <= wdog_next;
      err_reg  <= err_next;
    end
  end
`endif

  // Next-state decode and counter control outputs.
  always_comb begin
    state_next = state_reg;
    first_next = first_reg;
    last_next  = last_reg;
    LWCAN      = 1'b1;
    EC         = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
`ifdef CGA_MIC_INCSEQ_WDOG_EN
    wdog_next  = wdog_reg;
    err_next   = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (START) begin
          first_next = FIRST;
          last_next  = LAST;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        LWCAN      = 1'b0;
        BUSY       = 1'b1;
        state_next = ST_RUN;
`ifdef CGA_MIC_INCSEQ_WDOG_EN
        wdog_next  = 4'd0;
`endif
      end
      ST_RUN: begin
        BUSY = 1'b1;
        // Enable follows WRDY directly so the counter steps on the same
        // edge that accepts the word.
        EC   = WRDY;
        if (WRDY) begin
`ifdef CGA_MIC_INCSEQ_WDOG_EN
          wdog_next = 4'd0;
`endif
          if (count == last_reg) begin
            state_next = ST_FIN;
          end
        end else begin
`ifdef CGA_MIC_INCSEQ_WDOG_EN
          wdog_next = wdog_reg + 4'd1;
          if (wdog_next == WDOG_LIM4) begin
            state_next = ST_FIN;
            err_next   = 1'b1;
          end
`endif
        end
      end
      ST_FIN: begin
        DONE       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign CD0 = first_reg[0];
  assign CD1 = first_reg[1];

`ifdef CGA_MIC_INCSEQ_WDOG_EN
  assign ERR = err_reg;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cga_mic_incseq.sv
// Directed bench for cga_mic_incseq with a behavioural INCOUNT counter
// attached, so the sequencer sees real active-low read-back.
module tb_cga_mic_incseq;

  logic       MCLK = 1'b0;
  logic       MRN;
  logic       START;
  logic [1:0] FIRST, LAST;
  logic       WRDY;
  logic       CSWAN0, CSWAN1;
  logic       LWCAN, EC, CD0, CD1, BUSY, DONE, ERR;

  logic [1:0] n;
  int         compared = 0;
  int         mismatched = 0;
  int         ec_cnt, done_cnt;
  logic [6:0] pat;

  cga_mic_incseq #(.WDOG_LIM(4)) dut (
    .MCLK(MCLK), .MRN(MRN), .START(START), .FIRST(FIRST), .LAST(LAST),
    .WRDY(WRDY), .CSWAN0(CSWAN0), .CSWAN1(CSWAN1), .LWCAN(LWCAN), .EC(EC),
    .CD0(CD0), .CD1(CD1), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 MCLK = ~MCLK;

  // INCOUNT stand-in: load has priority over count, reset presets to 0.
  always @(posedge MCLK or negedge MRN) begin
    if (!MRN)        n <= 2'd0;
    else if (!LWCAN) n <= {CD1, CD0};
    else if (EC)     n <= n + 2'd1;
  end
  assign CSWAN0 = ~n[0];
  assign CSWAN1 = ~n[1];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #2;
  endtask

  initial begin
    MRN = 1'b0; START = 1'b0; FIRST = 2'd0; LAST = 2'd0; WRDY = 1'b0;
    #3;
    chk("rst_lwcan", 8'(LWCAN), 8'd1);
    chk("rst_ec",    8'(EC),    8'd0);
    chk("rst_busy",  8'(BUSY),  8'd0);
    chk("rst_done",  8'(DONE),  8'd0);
    chk("rst_err",   8'(ERR),   8'd0);
    chk("rst_cd",    8'({CD1, CD0}), 8'd0);
    tick();
    MRN = 1'b1;
    tick();

    // Single word FIRST=2 LAST=2
    START = 1'b1; FIRST = 2'd2; LAST = 2'd2; WRDY = 1'b1;
    #1;
    chk("sw_idle_ec",   8'(EC),   8'd0);
    chk("sw_idle_busy", 8'(BUSY), 8'd0);
    tick();
    START = 1'b0;
    #1;
    chk("sw_load_lwcan", 8'(LWCAN), 8'd0);
    chk("sw_load_cd",    8'({CD1, CD0}), 8'd2);
    chk("sw_load_ec",    8'(EC),    8'd0);
    chk("sw_load_busy",  8'(BUSY),  8'd1);
    tick();
    #1;
    chk("sw_run_n",   8'({CSWAN1, CSWAN0}), 8'd1);
    chk("sw_run_ec",  8'(EC),    8'd1);
    chk("sw_run_lw",  8'(LWCAN), 8'd1);
    tick();
    #1;
    chk("sw_fin_done", 8'(DONE), 8'd1);
    chk("sw_fin_err",  8'(ERR),  8'd0);
    chk("sw_fin_busy", 8'(BUSY), 8'd0);
    chk("sw_fin_ec",   8'(EC),   8'd0);
    chk("sw_fin_n",    8'(n),    8'd3);
    tick();
    #1;
    chk("sw_idle_done", 8'(DONE), 8'd0);
    $display("transfer single-word FIRST=2 LAST=2 end n=%0d", n);

    // Wrap FIRST=3 LAST=1, continuous WRDY
    START = 1'b1; FIRST = 2'd3; LAST = 2'd1; WRDY = 1'b1;
    tick();
    START = 1'b0;
    ec_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      ec_cnt   += int'(EC);
      done_cnt += int'(DONE);
      tick();
    end
    chk("wr_ec_pulses", 8'(ec_cnt),   8'd3);
    chk("wr_done_cnt",  8'(done_cnt), 8'd1);
    chk("wr_final_n",   8'(n),        8'd2);
    chk("wr_idle_busy", 8'(BUSY),     8'd0);
    $display("transfer wrap FIRST=3 LAST=1 ec=%0d done=%0d end n=%0d", ec_cnt, done_cnt, n);

    // Stalls with START held high; FIRST/LAST changed after acceptance
    WRDY = 1'b0; START = 1'b1; FIRST = 2'd0; LAST = 2'd3;
    tick();
    #1;
    chk("st_load_lwcan", 8'(LWCAN), 8'd0);
    chk("st_load_cd",    8'({CD1, CD0}), 8'd0);
    FIRST = 2'd1; LAST = 2'd1;
    pat = 7'b1011001; // applied LSB first: 1,0,0,1,1,0,1
    for (int i = 0; i < 7; i++) begin
      tick();
      WRDY = pat[i];
      #1;
      chk("st_run_ec",    8'(EC),    8'(pat[i]));
      chk("st_run_busy",  8'(BUSY),  8'd1);
      chk("st_run_lwcan", 8'(LWCAN), 8'd1);
      chk("st_run_done",  8'(DONE),  8'd0);
    end
    tick();
    WRDY = 1'b0;
    #1;
    chk("st_fin_done",  8'(DONE),  8'd1);
    chk("st_fin_lwcan", 8'(LWCAN), 8'd1);
    chk("st_fin_n",     8'(n),     8'd0);
    tick();
    LAST = 2'd3;
    #1;
    chk("st_idle_busy",  8'(BUSY),  8'd0);
    chk("st_idle_lwcan", 8'(LWCAN), 8'd1);
    chk("st_idle_done",  8'(DONE),  8'd0);
    $display("transfer stalls FIRST=0 LAST=3 end n=%0d", n);
    tick();
    START = 1'b0;
    #1;
    chk("rs_load_lwcan", 8'(LWCAN), 8'd0);
    chk("rs_load_cd",    8'({CD1, CD0}), 8'd1);

    // Reset mid-RUN (FIRST=1, LAST=3)
    tick();
    WRDY = 1'b1;
    #1;
    chk("rs_run_ec", 8'(EC), 8'd1);
    tick();
    WRDY = 1'b0;
    #1;
    chk("rs_run_n", 8'(n), 8'd2);
    MRN = 1'b0;
    #1;
    chk("ra_lwcan", 8'(LWCAN), 8'd1);
    chk("ra_ec",    8'(EC),    8'd0);
    chk("ra_busy",  8'(BUSY),  8'd0);
    chk("ra_done",  8'(DONE),  8'd0);
    chk("ra_err",   8'(ERR),   8'd0);
    chk("ra_cd",    8'({CD1, CD0}), 8'd0);
    chk("ra_cswan", 8'({CSWAN1, CSWAN0}), 8'd3);
    tick();
    #1;
    chk("ra_hold_done", 8'(DONE), 8'd0);
    chk("ra_hold_busy", 8'(BUSY), 8'd0);
    MRN = 1'b1;
    $display("transfer aborted by reset, n=%0d", n);

    // First START after release accepted on the first edge
    START = 1'b1; FIRST = 2'd2; LAST = 2'd0; WRDY = 1'b0;
    tick();
    START = 1'b0;
    #1;
    chk("pr_load_lwcan", 8'(LWCAN), 8'd0);
    tick();

`ifdef CGA_MIC_INCSEQ_WDOG_EN
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("wd_run_busy", 8'(BUSY), 8'd1);
      chk("wd_run_done", 8'(DONE), 8'd0);
      tick();
    end
    #1;
    chk("wd_done", 8'(DONE), 8'd1);
    chk("wd_err",  8'(ERR),  8'd1);
    tick();
    #1;
    chk("wd_after_err",  8'(ERR),  8'd0);
    chk("wd_after_done", 8'(DONE), 8'd0);
    $display("transfer watchdog abort");
`else
    for (int i = 0; i < 100; i++) begin
      #1;
      chk("nw_busy", 8'(BUSY), 8'd1);
      chk("nw_err",  8'(ERR),  8'd0);
      tick();
    end
    chk("nw_done", 8'(DONE), 8'd0);
    $display("transfer stalled 100 cycles without watchdog");
`endif

    MRN = 1'b0;
    #1;
    chk("end_busy", 8'(BUSY), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
